// File: rtl/div_pkg.sv
// Shared types and constants for the
// sequential divider scheduler.
package div_pkg;

  localparam int DEF_WIDTH = 8;
  localparam logic [63:0] DZ_Q = '1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/div_core.sv
// Restoring unsigned divide engine:
// one quotient bit per step.
module div_core
  import div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] d;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   t;
  logic             ge;

  assign t    = {rem, q[WIDTH-1]};
  assign ge   = t >= {1'b0, d};
  assign last = cnt == '0;
  assign r    = rem;

  // rem stays below d, so WIDTH bits hold it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q   <= '0;
      rem <= '0;
      d   <= '0;
      cnt <= '0;
    end else if (start) begin
      d <= b;
      if (b == '0) begin
        q   <= DZ_Q[WIDTH-1:0];
        rem <= a;
        cnt <= '0;
      end else begin
        q   <= a;
        rem <= '0;
        cnt <= CW'(WIDTH - 1);
      end
    end else if (step) begin
      rem <= ge ? WIDTH'(t - {1'b0, d})
                : t[WIDTH-1:0];
      q   <= {q[WIDTH-2:0], ge};
      if (!last) cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/div_scheduler.sv
// Round-robin arbiter, FSM and response
// port around one shared div_core.
module div_scheduler
  import div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_q,
  output logic [WIDTH-1:0] rsp_r,
  output logic             rsp_dz,
  output logic             busy
);

  state_t           state;
  state_t           nxt;
  logic             last_grant;
  logic             grant;
  logic             accept;
  logic             id;
  logic             dz;
  logic             last;
  logic             step;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;

  always_comb begin
    grant = 1'b0;
    unique case (1'b1)
      req0_valid & req1_valid:
        grant = ~last_grant;
      req1_valid & ~req0_valid:
        grant = 1'b1;
      default:
        grant = 1'b0;
    endcase
  end

  assign req0_ready = rst & (state == IDLE)
                    & req0_valid & ~grant;
  assign req1_ready = rst & (state == IDLE)
                    & req1_valid & grant;
  assign accept = req0_ready | req1_ready;

  assign op_a = grant ? req1_a : req0_a;
  assign op_b = grant ? req1_b : req0_b;

  // a zero divisor spends one frozen RUN cycle
  assign step = (state == RUN) & ~dz;

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (accept) nxt = RUN;
      RUN:  if (last) nxt = DONE;
      DONE: if (rsp_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      id         <= 1'b0;
      dz         <= 1'b0;
    end else begin
      state <= nxt;
      if (accept) begin
        last_grant <= grant;
        id         <= grant;
        dz         <= op_b == '0;
      end
    end
  end

  div_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk   (clk),
    .rst   (rst),
    .start (accept),
    .step  (step),
    .a     (op_a),
    .b     (op_b),
    .last  (last),
    .q     (rsp_q),
    .r     (rsp_r)
  );

  assign rsp_valid = state == DONE;
  assign busy      = state != IDLE;
  assign rsp_id    = id;
  assign rsp_dz    = dz;

endmodule

// File: tb/tb_div_scheduler.sv
// Scoreboard bench for div_scheduler with
// a round-robin and arithmetic reference.
module tb_div_scheduler;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         req0_valid;
  logic         req0_ready;
  logic [W-1:0] req0_a;
  logic [W-1:0] req0_b;
  logic         req1_valid;
  logic         req1_ready;
  logic [W-1:0] req1_a;
  logic [W-1:0] req1_b;
  logic         rsp_valid;
  logic         rsp_ready;
  logic         rsp_id;
  logic [W-1:0] rsp_q;
  logic [W-1:0] rsp_r;
  logic         rsp_dz;
  logic         busy;

  div_scheduler #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_q      (rsp_q),
    .rsp_r      (rsp_r),
    .rsp_dz     (rsp_dz),
    .busy       (busy)
  );

  typedef struct {
    logic         id;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           acc;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  logic m_last = 1'b1;
  logic m_idle = 1'b1;
  logic pv = 1'b0;
  logic pr = 1'b0;
  logic [18:0] snap = '0;
  logic rand_rdy = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got timeout expected done",
             nm);
  endtask

  // Reference: plain integer division with
  // the divide-by-zero convention.
  task automatic push(input logic id,
                      input logic [W-1:0] a,
                      input logic [W-1:0] b);
    exp_t e;
    int ai, bi;
    ai = int'(a);
    bi = int'(b);
    e.id  = id;
    e.acc = cyc;
    if (bi == 0) begin
      e.q   = 8'hFF;
      e.r   = a;
      e.dz  = 1'b1;
      e.lat = 2;
    end else begin
      e.q   = W'(ai / bi);
      e.r   = W'(ai % bi);
      e.dz  = 1'b0;
      e.lat = W + 1;
    end
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    logic e0, e1;
    if (!rst) begin
      chk("reset_outs",
          {rsp_valid, rsp_id, rsp_q, rsp_r,
           rsp_dz, busy, req0_ready, req1_ready},
          '0);
      sb.delete();
      m_last = 1'b1;
      m_idle = 1'b1;
      pv = 1'b0;
      pr = 1'b0;
    end else begin
      e0 = m_idle & req0_valid
         & (!req1_valid | m_last);
      e1 = m_idle & req1_valid
         & (!req0_valid | !m_last);
      chk("ready", {req0_ready, req1_ready},
          {e0, e1});
      chk("busy", busy, !m_idle);
      if (pv && !pr)
        chk("hold",
            {rsp_valid, rsp_id, rsp_q, rsp_r, rsp_dz},
            snap);
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL stale_rsp: got rsp_valid=1 expected 0");
        end else begin
          if (!pv)
            chk("latency", cyc - sb[0].acc,
                sb[0].lat);
          if (rsp_ready) begin
            chk("rsp",
                {rsp_id, rsp_q, rsp_r, rsp_dz},
                {sb[0].id, sb[0].q, sb[0].r,
                 sb[0].dz});
            void'(sb.pop_front());
            m_idle = 1'b1;
          end
        end
      end
      if (req0_valid && req0_ready) begin
        push(1'b0, req0_a, req0_b);
        m_idle = 1'b0;
        m_last = 1'b0;
      end
      if (req1_valid && req1_ready) begin
        push(1'b1, req1_a, req1_b);
        m_idle = 1'b0;
        m_last = 1'b1;
      end
      pv = rsp_valid;
      pr = rsp_ready;
      snap = {rsp_valid, rsp_id, rsp_q,
              rsp_r, rsp_dz};
    end
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      rsp_ready = $urandom_range(0, 3) != 0;
    end
  end

  task automatic issue(input logic v0,
                       input logic [W-1:0] a0,
                       input logic [W-1:0] b0,
                       input logic v1,
                       input logic [W-1:0] a1,
                       input logic [W-1:0] b1);
    int   n;
    logic p0, p1, h0, h1;
    n  = 0;
    p0 = v0;
    p1 = v1;
    req0_valid = p0;
    req0_a = a0;
    req0_b = b0;
    req1_valid = p1;
    req1_a = a1;
    req1_b = b1;
    while ((p0 || p1) && n < 300) begin
      @(negedge clk);
      h0 = req0_valid & req0_ready;
      h1 = req1_valid & req1_ready;
      @(posedge clk);
      #1;
      if (h0) begin
        p0 = 1'b0;
        req0_valid = 1'b0;
        req0_a = W'($urandom);
      end
      if (h1) begin
        p1 = 1'b0;
        req1_valid = 1'b0;
        req1_b = W'($urandom);
      end
      n++;
    end
    if (p0 || p1) begin
      fail_now("issue_wait");
      req0_valid = 1'b0;
      req1_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() > 0) fail_now("drain");
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] ra();
    int s;
    s = $urandom_range(0, 7);
    if (s == 0) return 8'hFF;
    if (s == 1) return 8'h00;
    return W'($urandom);
  endfunction

  function automatic logic [W-1:0] rb();
    int s;
    s = $urandom_range(0, 7);
    if (s == 0) return 8'h00;
    if (s == 1) return 8'h01;
    if (s == 2) return W'($urandom_range(2, 5));
    return W'($urandom);
  endfunction

  initial begin
    int n;
    logic [1:0] v;
    rst = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_a = '0;
    req0_b = '0;
    req1_a = '0;
    req1_b = '0;
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    issue(1'b1, 8'd200, 8'd7, 1'b0, 0, 0);
    drain();
    issue(1'b0, 0, 0, 1'b1, 8'd13, 8'd0);
    drain();
    issue(1'b0, 0, 0, 1'b1, 8'd7, 8'd200);
    drain();
    issue(1'b0, 0, 0, 1'b1, 8'd255, 8'd1);
    drain();

    rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    issue(1'b1, 8'd100, 8'd9, 1'b1, 8'd50, 8'd5);
    drain();
    issue(1'b1, 8'd100, 8'd9, 1'b1, 8'd50, 8'd5);
    drain();

    rsp_ready = 1'b0;
    issue(1'b1, 8'd20, 8'd3, 1'b0, 0, 0);
    req0_valid = 1'b1;
    req0_a = 8'd30;
    req0_b = 8'd4;
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(posedge clk);
      n++;
    end
    if (!rsp_valid) fail_now("bp_wait");
    repeat (5) @(posedge clk);
    #1 rsp_ready = 1'b1;
    issue(1'b1, 8'd30, 8'd4, 1'b0, 0, 0);
    drain();

    issue(1'b1, 8'd255, 8'd16, 1'b0, 0, 0);
    repeat (3) @(posedge clk);
    #3;
    chk("busy_midrun", busy, 1'b1);
    rst = 1'b0;
    #1;
    chk("async_reset",
        {rsp_valid, rsp_id, rsp_q, rsp_r,
         rsp_dz, busy, req0_ready, req1_ready},
        '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    issue(1'b1, 8'd255, 8'd16, 1'b0, 0, 0);
    drain();

    rand_rdy = 1'b1;
    for (int i = 0; i < 1200; i++) begin
      v = 2'($urandom_range(1, 3));
      issue(v[0], ra(), rb(), v[1], ra(), rb());
      if ($urandom_range(0, 3) == 0)
        repeat ($urandom_range(1, 12))
          @(posedge clk);
      #1;
    end
    rand_rdy = 1'b0;
    @(posedge clk);
    #2 rsp_ready = 1'b1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
